// File: rtl/udp_rx_checker.sv
// ============================================================================
// udp_rx_checker: parses a beat-streamed UDP datagram, checks length, port
// and ones-complement checksum, and reports one result per datagram.
// Revision: 1.0
// ============================================================================
`default_nettype none

module udp_rx_checker #(
  parameter int          DATA_W       = 64,
  parameter int          MAX_LEN      = 1500,
  parameter bit          PORT_FILT_EN = 1'b0,
  parameter logic [15:0] DST_PORT     = 16'h0003
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_pass,
  output logic [1:0]        out_err,
  output logic [15:0]       out_src,
  output logic [15:0]       out_dst,
  output logic [15:0]       out_len,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       err_cnt
);

  localparam int          c_LANES   = DATA_W / 16;
  localparam logic [15:0] c_BYTES   = 16'(DATA_W / 8);
  localparam logic [15:0] c_MAX_LEN = 16'(MAX_LEN);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_HDR1 = 3'd1;
  localparam logic [2:0] c_PAY  = 3'd2;
  localparam logic [2:0] c_FOLD = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  logic [2:0]  r_state, w_next;
  logic [31:0] r_acc;
  logic [15:0] r_src, r_dst, r_len, r_cksum, r_rem;
  logic [1:0]  r_err;
  logic        r_pass;
  logic [15:0] r_out_src, r_out_dst, r_out_len, r_ok_cnt, r_err_cnt;

  logic [15:0] w_hdr_len;
  logic        w_hdr_bad, w_len_bad, w_last;
  logic [15:0] w_lane [c_LANES];
  logic [31:0] w_pay_sum;
  logic [16:0] w_f1;
  logic [15:0] w_f2;
  logic [1:0]  w_err;

  assign w_hdr_len = in_data[31:16];
  assign w_hdr_bad = (w_hdr_len < 16'd8) || (w_hdr_len > c_MAX_LEN);
  assign w_len_bad = (r_len < 16'd8) || (r_len > c_MAX_LEN);
  // r_rem holds payload bytes still owed; this beat is the last when it fits
  assign w_last    = (r_rem <= c_BYTES);

  for (genvar i = 0; i < c_LANES; i++) begin : g_lane
    localparam logic [15:0] c_HI_IDX = 16'(2 * i);
    localparam logic [15:0] c_LO_IDX = 16'(2 * i + 1);
    assign w_lane[i] = {(r_rem > c_HI_IDX) ? in_data[DATA_W-1-16*i -: 8] : 8'h00,
                        (r_rem > c_LO_IDX) ? in_data[DATA_W-9-16*i -: 8] : 8'h00};
  end

  always_comb begin : p_pay_sum
    w_pay_sum = '0;
    for (int k = 0; k < c_LANES; k++) begin
      w_pay_sum = w_pay_sum + {16'h0000, w_lane[k]};
    end
  end

  // Two end-around-carry folds; the second can never carry out again
  assign w_f1 = {1'b0, r_acc[15:0]} + {1'b0, r_acc[31:16]};
  assign w_f2 = w_f1[15:0] + {15'h0000, w_f1[16]};

  always_comb begin : p_err
    w_err = 2'd0;
    if (w_len_bad)                                    w_err = 2'd1;
    else if (PORT_FILT_EN && (r_dst != DST_PORT))     w_err = 2'd3;
    else if ((r_cksum != 16'h0000) && (w_f2 != 16'hFFFF)) w_err = 2'd2;
  end

  always_ff @(posedge clk) begin : p_state
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin : p_next
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (in_valid) w_next = c_HDR1;
      c_HDR1:  if (in_valid) w_next = (w_hdr_bad || (w_hdr_len == 16'd8)) ? c_FOLD : c_PAY;
      c_PAY:   if (in_valid && w_last) w_next = c_FOLD;
      c_FOLD:  w_next = c_DONE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin : p_out
    in_ready  = (r_state == c_IDLE) || (r_state == c_HDR1) || (r_state == c_PAY);
    out_valid = (r_state == c_DONE);
  end

  always_ff @(posedge clk) begin : p_data
    if (rst) begin
      r_acc     <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_cksum   <= '0;
      r_rem     <= '0;
      r_err     <= '0;
      r_pass    <= 1'b0;
      r_out_src <= '0;
      r_out_dst <= '0;
      r_out_len <= '0;
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: if (in_valid) begin
          r_src <= in_data[31:16];
          r_dst <= in_data[15:0];
          r_acc <= {16'h0000, in_data[31:16]} + {16'h0000, in_data[15:0]};
        end
        c_HDR1: if (in_valid) begin
          r_len   <= w_hdr_len;
          r_cksum <= in_data[15:0];
          r_acc   <= r_acc + {16'h0000, w_hdr_len} + {16'h0000, in_data[15:0]};
          r_rem   <= w_hdr_len - 16'd8;
        end
        c_PAY: if (in_valid) begin
          r_acc <= r_acc + w_pay_sum;
          r_rem <= r_rem - c_BYTES;
        end
        c_FOLD: begin
          r_err     <= w_err;
          r_pass    <= (w_err == 2'd0);
          r_out_src <= r_src;
          r_out_dst <= r_dst;
          r_out_len <= r_len;
        end
        c_DONE: begin
          r_acc <= '0;
          if (r_pass) r_ok_cnt  <= r_ok_cnt + 16'd1;
          else        r_err_cnt <= r_err_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_pass = r_pass;
  assign out_err  = r_err;
  assign out_src  = r_out_src;
  assign out_dst  = r_out_dst;
  assign out_len  = r_out_len;
  assign ok_cnt   = r_ok_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

`default_nettype wire
